// File: rtl/spectrum_pkg.sv
// Shared constants and types for the spectrum bar reader.
// Holds the bus geometry, quantizer settings, FSM state encoding and the
// small index/level types used by the top and the quantizer.
package spectrum_pkg;

    localparam int unsigned NUM_BINS    = 16;
    localparam int unsigned MAG_W       = 16;
    localparam int unsigned LEVELS      = 8;
    localparam int unsigned LEVEL_W     = 4;
    localparam int unsigned BASE        = 16;
    localparam int unsigned HOLD_FRAMES = 2;

    localparam int unsigned BIN_W  = $clog2(NUM_BINS);
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef logic [BIN_W-1:0]   bin_idx_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [HOLD_W-1:0]  hold_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/bar_level_quantizer.sv
// Logarithmic bar quantizer (combinational).
// Height is the number of thresholds BASE<<k (k = 0..LEVELS-1) that the
// magnitude meets or exceeds, giving 0..LEVELS.
// Ports:
//   mag     in   MAG_W    unsigned magnitude of one bin
//   height  out  LEVEL_W  bar height 0..LEVELS
module bar_level_quantizer
    import spectrum_pkg::*;
#(
    parameter int unsigned Q_MAG_W   = MAG_W,
    parameter int unsigned Q_LEVELS  = LEVELS,
    parameter int unsigned Q_LEVEL_W = LEVEL_W,
    parameter int unsigned Q_BASE    = BASE
) (
    input  logic [Q_MAG_W-1:0]   mag,
    output logic [Q_LEVEL_W-1:0] height
);

    always_comb begin
        height = '0;
        for (int unsigned k = 0; k < Q_LEVELS; k++) begin
            // Compare at 64 bits so thresholds beyond the magnitude range never match.
            if (64'(mag) >= (64'(Q_BASE) << k)) begin
                height = height + Q_LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/spectrum_bar_reader.sv
// Spectrum bar reader.
// Captures one packed magnitude frame per handshake, walks the bins one per
// cycle through a shared quantizer, applies bar fall-off and peak-hold, and
// publishes the whole frame at once with a single-cycle strobe.
// Ports:
//   clk           in   1                  system clock
//   rst_n         in   1                  asynchronous active-low reset
//   mag_valid     in   1                  magnitude frame available
//   mag           in   NUM_BINS*MAG_W     packed magnitudes, bin 0 at MSBs
//   mag_ready     out  1                  frame can be accepted (idle)
//   bar_heights   out  NUM_BINS*LEVEL_W   smoothed bar levels, bin 0 at MSBs
//   peak_heights  out  NUM_BINS*LEVEL_W   peak-hold levels, bin 0 at MSBs
//   bars_valid    out  1                  one-cycle pulse on output update
module spectrum_bar_reader
    import spectrum_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mag_valid,
    input  logic [NUM_BINS*MAG_W-1:0]   mag,
    output logic                        mag_ready,
    output logic [NUM_BINS*LEVEL_W-1:0] bar_heights,
    output logic [NUM_BINS*LEVEL_W-1:0] peak_heights,
    output logic                        bars_valid
);

    localparam bin_idx_t LAST_BIN = bin_idx_t'(NUM_BINS - 1);

    state_e                        state_q, state_d;
    bin_idx_t                      bin_q;
    logic [NUM_BINS*MAG_W-1:0]     cap_q;
    level_t                        bar_q  [NUM_BINS];
    level_t                        peak_q [NUM_BINS];
    hold_t                         hold_q [NUM_BINS];
    logic [NUM_BINS*LEVEL_W-1:0]   bar_out_q, peak_out_q;
    logic                          bars_valid_q;

    logic [MAG_W-1:0] cur_mag;
    level_t           h, bar_cur, peak_cur, bar_new, peak_new, peak_dec;
    hold_t            hold_cur, hold_new;

    bar_level_quantizer #(
        .Q_MAG_W   (MAG_W),
        .Q_LEVELS  (LEVELS),
        .Q_LEVEL_W (LEVEL_W),
        .Q_BASE    (BASE)
    ) u_quant (
        .mag    (cur_mag),
        .height (h)
    );

    // Per-bin update for the bin currently addressed by the counter.
    always_comb begin
        cur_mag  = cap_q[(NUM_BINS - 1 - 32'(bin_q)) * MAG_W +: MAG_W];
        bar_cur  = bar_q[bin_q];
        peak_cur = peak_q[bin_q];
        hold_cur = hold_q[bin_q];

        // h < bar implies bar >= 1, so the decrement cannot wrap.
        bar_new  = (h >= bar_cur) ? h : bar_cur - level_t'(1);

        peak_dec = peak_cur - level_t'(1);
        peak_new = peak_cur;
        hold_new = hold_cur;
        if (h >= peak_cur) begin
            peak_new = h;
            hold_new = hold_t'(HOLD_FRAMES);
        end else if (hold_cur != '0) begin
            hold_new = hold_cur - hold_t'(1);
        end else begin
            // Decay, but never drop below the bar just computed.
            peak_new = (peak_dec > bar_new) ? peak_dec : bar_new;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mag_valid) state_d = StScan;
            StScan:  if (bin_q == LAST_BIN) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bin_q        <= '0;
            cap_q        <= '0;
            bar_out_q    <= '0;
            peak_out_q   <= '0;
            bars_valid_q <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bar_q[i]  <= '0;
                peak_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            bars_valid_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (mag_valid) begin
                        cap_q <= mag;
                        bin_q <= '0;
                    end
                end
                StScan: begin
                    bar_q[bin_q]  <= bar_new;
                    peak_q[bin_q] <= peak_new;
                    hold_q[bin_q] <= hold_new;
                    bin_q         <= bin_q + bin_idx_t'(1);
                end
                StDone: begin
                    for (int i = 0; i < NUM_BINS; i++) begin
                        bar_out_q[(NUM_BINS - 1 - i) * LEVEL_W +: LEVEL_W]  <= bar_q[i];
                        peak_out_q[(NUM_BINS - 1 - i) * LEVEL_W +: LEVEL_W] <= peak_q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign mag_ready    = (state_q == StIdle);
    assign bar_heights  = bar_out_q;
    assign peak_heights = peak_out_q;
    assign bars_valid   = bars_valid_q;

endmodule
